// File: rtl/riscv_rf_mp_pkg.sv
// Shared constants and types for the multi-port integer register file.
package riscv_rf_mp_pkg;

    localparam int RF_ADDR_SIZE = 5;

    // Debug-unit register access sequencing
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } du_rf_state_t;

    // In RV32E only x0..x15 exist, so any address with the top bit set is illegal
    function automatic logic rf_addr_legal(input logic [RF_ADDR_SIZE-1:0] addr,
                                           input logic                    rv32e);
        return !(rv32e && addr[RF_ADDR_SIZE-1]);
    endfunction

endpackage

// File: rtl/riscv_rf_mp_dbg_port.sv
// Debug-unit access port: req/ack handshake, yields to pipeline writes,
// captures the pre-write register value into du_dato.
module riscv_rf_dbg_port
    import riscv_rf_mp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            du_stall,
    input  logic            du_req,
    input  logic            du_we,
    input  logic            rf_busy,    // any pipeline write this cycle
    input  logic            addr_ok,    // debug address legal and nonzero
    input  logic [XLEN-1:0] rdata,      // current contents at du_addr
    output logic [XLEN-1:0] du_dato,
    output logic            du_ack,
    output logic            dbg_we      // commit du_dati this cycle
);

    du_rf_state_t state;

    // Access completes only when the pipeline is not writing and the request is still up
    logic go;
    assign go     = (state == ACCESS) && !rf_busy && du_req;
    assign dbg_we = go && du_we && addr_ok;

    // Debug FSM with registered ack/data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            du_ack  <= 1'b0;
            du_dato <= '0;
        end else begin
            du_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (du_req && du_stall) state <= ACCESS;
                end
                ACCESS: begin
                    if (rf_busy) begin
                        state <= ACCESS;
                    end else if (!du_req) begin
                        state <= IDLE;
                    end else begin
                        du_dato <= rdata;
                        du_ack  <= 1'b1;
                        state   <= ACK;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/riscv_rf_mp.sv
// Parametrised multi-port integer register file with optional write->read
// bypass, RV32E mode and an arbitrated debug access port.
module riscv_rf_mp
    import riscv_rf_mp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RDPORTS   = 2,
    parameter int WRPORTS   = 1,
    parameter int IS_RV32E  = 0,
    parameter int BYPASS    = 1,
    parameter int RST_CLEAR = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [RDPORTS-1:0][RF_ADDR_SIZE-1:0]    rf_src,
    output logic [RDPORTS-1:0][XLEN-1:0]            rf_srcv,
    output logic [RDPORTS-1:0]                      rf_srcill,
    input  logic [WRPORTS-1:0][RF_ADDR_SIZE-1:0]    rf_dst,
    input  logic [WRPORTS-1:0][XLEN-1:0]            rf_dstv,
    input  logic [WRPORTS-1:0]                      rf_we,
    input  logic                                    du_stall,
    input  logic                                    du_req,
    input  logic                                    du_we,
    input  logic [RF_ADDR_SIZE-1:0]                 du_addr,
    input  logic [XLEN-1:0]                         du_dati,
    output logic [XLEN-1:0]                         du_dato,
    output logic                                    du_ack
);

    localparam int NREGS = (IS_RV32E != 0) ? 16 : 32;

    if (RDPORTS < 1 || RDPORTS > 4) begin : g_bad_rdports
        $error("riscv_rf_mp: RDPORTS must be 1..4");
    end
    if (WRPORTS < 1 || WRPORTS > 2) begin : g_bad_wrports
        $error("riscv_rf_mp: WRPORTS must be 1..2");
    end

    // Full 32-entry view; x0 and non-existent registers are tied to zero so
    // indexing with any 5-bit address is safe and returns 0 for them.
    logic [31:0][XLEN-1:0] rf_q;

    logic            dbg_we;
    logic            dbg_addr_ok;
    logic [XLEN-1:0] dbg_rdata;

    assign dbg_addr_ok = (du_addr != '0) && rf_addr_legal(du_addr, IS_RV32E != 0);
    assign dbg_rdata   = rf_q[du_addr];

    for (genvar r = 0; r < 32; r++) begin : g_reg
        if (r == 0 || r >= NREGS) begin : g_none
            assign rf_q[r] = '0;
        end else begin : g_store
            logic [XLEN-1:0] q;
            logic [XLEN-1:0] nxt;
            logic            hit;

            // Write select: later ports override earlier ones; a full 5-bit
            // compare drops RV32E writes to x16..x31 and writes to x0.
            always_comb begin
                hit = 1'b0;
                nxt = q;
                for (int p = 0; p < WRPORTS; p++) begin
                    if (rf_we[p] && rf_dst[p] == RF_ADDR_SIZE'(r)) begin
                        hit = 1'b1;
                        nxt = rf_dstv[p];
                    end
                end
                // Only fires when no pipeline write is active
                if (dbg_we && du_addr == RF_ADDR_SIZE'(r)) begin
                    hit = 1'b1;
                    nxt = du_dati;
                end
            end

            // Register storage, optionally cleared by reset
            always_ff @(posedge clk) begin
                if (rst && (RST_CLEAR != 0)) q <= '0;
                else if (hit)                q <= nxt;
            end

            assign rf_q[r] = q;
        end
    end

    for (genvar i = 0; i < RDPORTS; i++) begin : g_rd
        logic            ill;
        logic [XLEN-1:0] v;

        assign ill = (IS_RV32E != 0) && rf_src[i][RF_ADDR_SIZE-1];

        // Read mux with same-cycle forwarding; highest write port wins
        always_comb begin
            v = rf_q[rf_src[i]];
            if (BYPASS != 0 && rf_src[i] != '0) begin
                for (int p = 0; p < WRPORTS; p++) begin
                    if (rf_we[p] && rf_dst[p] == rf_src[i]) v = rf_dstv[p];
                end
            end
            if (ill) v = '0;
        end

        assign rf_srcv[i]   = v;
        assign rf_srcill[i] = ill;
    end

    riscv_rf_dbg_port #(
        .XLEN (XLEN)
    ) u_dbg (
        .clk      (clk),
        .rst      (rst),
        .du_stall (du_stall),
        .du_req   (du_req),
        .du_we    (du_we),
        .rf_busy  (|rf_we),
        .addr_ok  (dbg_addr_ok),
        .rdata    (dbg_rdata),
        .du_dato  (du_dato),
        .du_ack   (du_ack),
        .dbg_we   (dbg_we)
    );

endmodule

// File: tb/tb_riscv_rf_mp.sv
// Directed bench for riscv_rf_mp: a 2R/2W bypassing instance and a
// 2R/1W RV32E non-bypassing instance.
module tb_riscv_rf_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: 2 read, 2 write, bypass, RV32I
    logic [1:0][4:0]  rf_src;
    logic [1:0][31:0] rf_srcv;
    logic [1:0]       rf_srcill;
    logic [1:0][4:0]  rf_dst;
    logic [1:0][31:0] rf_dstv;
    logic [1:0]       rf_we;
    logic             du_stall, du_req, du_we, du_ack;
    logic [4:0]       du_addr;
    logic [31:0]      du_dati, du_dato;

    riscv_rf_mp #(.XLEN(32), .RDPORTS(2), .WRPORTS(2), .IS_RV32E(0), .BYPASS(1), .RST_CLEAR(1)) dut (
        .clk(clk), .rst(rst), .rf_src(rf_src), .rf_srcv(rf_srcv), .rf_srcill(rf_srcill),
        .rf_dst(rf_dst), .rf_dstv(rf_dstv), .rf_we(rf_we), .du_stall(du_stall), .du_req(du_req),
        .du_we(du_we), .du_addr(du_addr), .du_dati(du_dati), .du_dato(du_dato), .du_ack(du_ack));

    // RV32E instance without bypass
    logic [1:0][4:0]  e_src;
    logic [1:0][31:0] e_srcv;
    logic [1:0]       e_ill;
    logic [0:0][4:0]  e_dst;
    logic [0:0][31:0] e_dstv;
    logic [0:0]       e_we;
    logic [31:0]      e_du_dato;
    logic             e_du_ack;

    riscv_rf_mp #(.XLEN(32), .RDPORTS(2), .WRPORTS(1), .IS_RV32E(1), .BYPASS(0), .RST_CLEAR(1)) dut_e (
        .clk(clk), .rst(rst), .rf_src(e_src), .rf_srcv(e_srcv), .rf_srcill(e_ill),
        .rf_dst(e_dst), .rf_dstv(e_dstv), .rf_we(e_we), .du_stall(1'b0), .du_req(1'b0),
        .du_we(1'b0), .du_addr(5'd0), .du_dati(32'd0), .du_dato(e_du_dato), .du_ack(e_du_ack));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we0;  logic [4:0] dst0; logic [31:0] d0;
        logic        we1;  logic [4:0] dst1; logic [31:0] d1;
        logic [4:0]  s0;   logic [4:0] s1;
        logic [31:0] e0;   logic [31:0] e1;
    } vec_t;

    vec_t vt[12];

    // Debug access; we_hold>0 keeps pipeline port0 writing x10 for that many
    // cycles once the FSM is in ACCESS. lat counts clock edges to du_ack.
    task automatic dbg_access(input logic we, input logic [4:0] addr, input logic [31:0] dati,
                              input int we_hold, output int lat, output logic [31:0] dato);
        @(negedge clk);
        du_stall = 1'b1; du_req = 1'b1; du_we = we; du_addr = addr; du_dati = dati;
        lat = 0;
        dato = 'x;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (du_ack === 1'b1) break;
            rf_we[0]   = (lat <= we_hold);
            rf_dst[0]  = 5'd10;
            rf_dstv[0] = 32'(lat);
        end
        dato = du_dato;
        du_req = 1'b0;
        rf_we  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        int          cnt;
        logic [31:0] dato;

        rst = 1'b1;
        rf_src = '0; rf_dst = '0; rf_dstv = '0; rf_we = '0;
        du_stall = 1'b0; du_req = 1'b0; du_we = 1'b0; du_addr = '0; du_dati = '0;
        e_src = '0; e_dst = '0; e_dstv = '0; e_we = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_du_ack", du_ack, 0);
        chk("reset_du_dato", du_dato, 0);

        // Dirty some registers, then reset and expect everything cleared
        rf_we = 2'b11; rf_dst[0] = 5'd3; rf_dstv[0] = 32'h3333; rf_dst[1] = 5'd9; rf_dstv[1] = 32'h9999;
        @(negedge clk);
        rf_we = '0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 1; a < 32; a++) begin
            rf_src[0] = 5'(a); rf_src[1] = 5'(a);
            #1;
            chk($sformatf("rst_clear_p0_x%0d", a), rf_srcv[0], 0);
            chk($sformatf("rst_clear_p1_x%0d", a), rf_srcv[1], 0);
        end
        chk("rst_ack_after", du_ack, 0);

        //          we0 dst0   d0            we1 dst1   d1            s0     s1     e0            e1
        vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vt[2]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  32'h22,       32'h22};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h22,       32'hDEADBEEF};
        vt[4]  = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h22};
        vt[6]  = '{1'b1, 5'd31, 32'h12345678, 1'b1, 5'd1,  32'hCAFEF00D, 5'd31, 5'd1,  32'h12345678, 32'hCAFEF00D};
        vt[7]  = '{1'b0, 5'd31, 32'hAAAA0000, 1'b0, 5'd0,  32'h0,        5'd31, 5'd1,  32'h12345678, 32'hCAFEF00D};
        vt[8]  = '{1'b1, 5'd2,  32'h2,        1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd2,  32'hFFFFFFFF, 32'h2};
        vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd2,  32'hFFFFFFFF, 32'h2};
        vt[10] = '{1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  32'h0,        5'd3,  5'd5,  32'h33,       32'hDEADBEEF};
        vt[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd7,  32'h33,       32'h22};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rf_we[0] = vt[i].we0; rf_dst[0] = vt[i].dst0; rf_dstv[0] = vt[i].d0;
            rf_we[1] = vt[i].we1; rf_dst[1] = vt[i].dst1; rf_dstv[1] = vt[i].d1;
            rf_src[0] = vt[i].s0; rf_src[1] = vt[i].s1;
            #1;
            chk($sformatf("vec%0d_p0", i), rf_srcv[0], vt[i].e0);
            chk($sformatf("vec%0d_p1", i), rf_srcv[1], vt[i].e1);
        end
        chk("rv32i_srcill", 32'(rf_srcill), 0);
        @(negedge clk);
        rf_we = '0;

        // RV32E, no bypass
        e_we[0] = 1'b1; e_dst[0] = 5'd4; e_dstv[0] = 32'h44; e_src[0] = 5'd4; e_src[1] = 5'd5;
        #1;
        chk("e_nobypass_x4_old", e_srcv[0], 0);
        @(negedge clk);
        e_we[0] = 1'b1; e_dst[0] = 5'd5; e_dstv[0] = 32'hDEADBEEF;
        #1;
        chk("e_x4_written", e_srcv[0], 32'h44);
        chk("e_nobypass_x5_old", e_srcv[1], 0);
        @(negedge clk);
        e_we[0] = 1'b1; e_dst[0] = 5'd20; e_dstv[0] = 32'h1; e_src[0] = 5'd20;
        #1;
        chk("e_x5_next_cycle", e_srcv[1], 32'hDEADBEEF);
        chk("e_x20_read_zero", e_srcv[0], 0);
        chk("e_x20_ill", 32'(e_ill[0]), 1);
        chk("e_x5_ill", 32'(e_ill[1]), 0);
        @(negedge clk);
        e_we[0] = 1'b0; e_src[0] = 5'd4; e_src[1] = 5'd20;
        #1;
        chk("e_x4_unchanged", e_srcv[0], 32'h44);
        chk("e_x4_ill", 32'(e_ill[0]), 0);
        chk("e_x20_after", e_srcv[1], 0);
        chk("e_x20_ill_p1", 32'(e_ill[1]), 1);

        // Debug write x3 (old 0x33)
        rf_src[0] = 5'd3;
        dbg_access(1'b1, 5'd3, 32'hA5, 0, lat, dato);
        chk("dbg_w_latency", 32'(lat), 2);
        chk("dbg_w_dato_old", dato, 32'h33);
        #1;
        chk("dbg_w_visible", rf_srcv[0], 32'hA5);
        @(negedge clk);
        chk("dbg_ack_one_cycle", du_ack, 0);
        chk("dbg_dato_hold", du_dato, 32'h33);

        // Debug write x12 while pipeline writes for 3 cycles
        rf_src[0] = 5'd12; rf_src[1] = 5'd10;
        dbg_access(1'b1, 5'd12, 32'hB2, 3, lat, dato);
        chk("dbg_stall_latency", 32'(lat), 5);
        chk("dbg_stall_dato", dato, 0);
        #1;
        chk("dbg_stall_x12", rf_srcv[0], 32'hB2);
        chk("dbg_stall_x10", rf_srcv[1], 32'd3);

        // Debug reads
        rf_src[0] = 5'd7;
        dbg_access(1'b0, 5'd7, 32'hFFFF, 0, lat, dato);
        chk("dbg_r_latency", 32'(lat), 2);
        chk("dbg_r_dato_x7", dato, 32'h22);
        #1;
        chk("dbg_r_x7_kept", rf_srcv[0], 32'h22);
        rf_src[0] = 5'd0;
        dbg_access(1'b1, 5'd0, 32'h77, 0, lat, dato);
        chk("dbg_x0_dato", dato, 0);
        #1;
        chk("dbg_x0_not_written", rf_srcv[0], 0);

        // Request withdrawn in ACCESS: no ack
        @(negedge clk);
        du_stall = 1'b1; du_req = 1'b1; du_we = 1'b0; du_addr = 5'd5;
        @(negedge clk);
        du_req = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (du_ack !== 1'b0) cnt++;
        end
        chk("dbg_withdraw_no_ack", 32'(cnt), 0);

        // Request without stall: ignored
        @(negedge clk);
        du_stall = 1'b0; du_req = 1'b1; du_we = 1'b1; du_addr = 5'd5; du_dati = 32'h1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (du_ack !== 1'b0) cnt++;
        end
        du_req = 1'b0;
        chk("dbg_nostall_no_ack", 32'(cnt), 0);
        rf_src[1] = 5'd5;
        #1;
        chk("dbg_nostall_x5", rf_srcv[1], 32'hDEADBEEF);

        // Reset while in ACCESS: dropped, FSM idle afterwards
        @(negedge clk);
        du_stall = 1'b1; du_req = 1'b1; du_we = 1'b0; du_addr = 5'd5;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; du_req = 1'b0;
        chk("rst_mid_ack", du_ack, 0);
        chk("rst_mid_dato", du_dato, 0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (du_ack !== 1'b0) cnt++;
        end
        chk("rst_mid_no_ack", 32'(cnt), 0);
        dbg_access(1'b0, 5'd5, 32'h0, 0, lat, dato);
        chk("rst_mid_idle_latency", 32'(lat), 2);
        chk("rst_mid_x5_cleared", dato, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
